blink_field_ctrl: RTL
=====================

// Module: blink_field_ctrl
// PURPOSE
//  Edit-mode blink scheduler for the six-digit seven-segment display (HH:MM:SS).
//  Tracks the field being edited (2 digits per field) and toggles a blink phase.
//  Drives the per-digit isOn enables of the blink display gating stage.
//  Sits between the button debouncers/mode FSM and the per-digit display blankers.
// PARAMETERS
//  NUM_FIELDS   3           number of 2-digit fields; digits = 2*NUM_FIELDS
//  HALF_PERIOD  25_000_000  clk cycles per blink half-period (on or off); >= 2
//  CNT_W        25          phase counter width; 2**CNT_W >= HALF_PERIOD
// PORTS
//  clk        in   1             system clock, rising edge
//  rst_n      in   1             asynchronous active-low reset
//  edit_req   in   1             1-cycle pulse: enter edit mode
//  exit_req   in   1             1-cycle pulse: leave edit mode
//  next_req   in   1             1-cycle pulse: advance cursor to next field
//  editing    out  1             1 while in edit mode (registered)
//  cursor     out  2             index of field being edited, 0..NUM_FIELDS-1
//  blink_ph   out  1             1 = SHOW half, 0 = HIDE half; 1 when not editing
//  digit_on   out  2*NUM_FIELDS  per-digit isOn; bits [2c+1:2c] belong to field c
// BEHAVIOUR
//  Reset (async, rst_n=0): state IDLE, cnt=0, cursor=0, editing=0, blink_ph=1,
//   digit_on=all 1s. Release is synchronous to the next clk edge.
//  States: IDLE, SHOW, HIDE. All outputs registered; 1-cycle latency from req.
//  IDLE: edit_req & !exit_req -> SHOW, cnt=0, cursor=0. Other reqs ignored.
//  SHOW/HIDE: cnt increments each cycle; at cnt==HALF_PERIOD-1, cnt=0 and
//   SHOW<->HIDE toggle. So each half lasts exactly HALF_PERIOD cycles.
//  next_req in SHOW/HIDE: cursor = (cursor==NUM_FIELDS-1) ? 0 : cursor+1;
//   state forced to SHOW, cnt=0 (new field shown immediately, full half).
//  exit_req in SHOW/HIDE: -> IDLE, cnt=0; cursor held (last edited field).
//  Priority same cycle: exit_req > next_req > counter terminal toggle.
//  edit_req while editing: ignored (no restart, no cursor change).
//  editing = (state != IDLE); blink_ph = (state != HIDE).
//  digit_on: IDLE -> all 1s; editing -> all 1s except the two bits of the
//   cursor field, which equal blink_ph.
//  cursor never leaves 0..NUM_FIELDS-1; cnt never exceeds HALF_PERIOD-1.
//  Reset mid-edit: immediate return to reset values regardless of state/cnt.
// TESTING (bench uses NUM_FIELDS=3, HALF_PERIOD=4)
//  Reset: hold rst_n=0 -> editing=0, cursor=0, blink_ph=1, digit_on=6'b111111.
//  edit_req pulse -> next cycle editing=1, digit_on=111111 for 4 cycles, then
//   6'b111100 for 4 cycles, repeating.
//  Three next_req pulses -> cursor 1,2,0; after each, digit_on bits of the new
//   field are 1 for a full 4 cycles (e.g. cursor=1 HIDE -> 6'b110011).
//  next_req during HIDE at cnt=2 -> next cycle SHOW, cnt restarts; no 1-cycle
//   glitch in digit_on.
//  exit_req and next_req same cycle at cursor=2 -> IDLE, cursor stays 2,
//   digit_on=111111; edit_req while editing leaves cursor/phase unchanged.
//  rst_n low for 1 cycle mid-HIDE -> all outputs at reset values asynchronously.

Source files
------------

// File: rtl/blink_field_ctrl.sv
// Edit-mode blink scheduler for the HH:MM:SS seven-segment display.
// Tracks which 2-digit field is under edit and alternates a SHOW/HIDE phase.
// The per-digit enables are registered and feed the digit blankers directly.
module blink_field_ctrl #(
  parameter int unsigned NUM_FIELDS  = 3,
  parameter int unsigned HALF_PERIOD = 25_000_000,
  parameter int unsigned CNT_W       = 25
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    edit_req,
  input  logic                    exit_req,
  input  logic                    next_req,
  output logic                    editing,
  output logic [1:0]              cursor,
  output logic                    blink_ph,
  output logic [2*NUM_FIELDS-1:0] digit_on
);

  localparam int unsigned NumDigits = 2 * NUM_FIELDS;
  localparam logic [CNT_W-1:0] CntLast = CNT_W'(HALF_PERIOD - 1);
  localparam logic [1:0] CursorLast = 2'(NUM_FIELDS - 1);

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StShow = 2'd1,
    StHide = 2'd2
  } state_e;

  state_e                 state_q, state_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic [1:0]             cursor_q, cursor_d;
  logic                   editing_q, editing_d;
  logic                   blink_ph_q, blink_ph_d;
  logic [NumDigits-1:0]   digit_on_q, digit_on_d;

  // Next-state: exit beats next, next beats the half-period toggle.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    cursor_d = cursor_q;
    unique case (state_q)
      StIdle: begin
        if (edit_req && !exit_req) begin
          state_d  = StShow;
          cnt_d    = '0;
          cursor_d = 2'd0;
        end
      end
      StShow, StHide: begin
        if (exit_req) begin
          // Cursor is kept so the last edited field is remembered.
          state_d = StIdle;
          cnt_d   = '0;
        end else if (next_req) begin
          // New field starts visible for a full half-period.
          state_d  = StShow;
          cnt_d    = '0;
          cursor_d = (cursor_q == CursorLast) ? 2'd0 : cursor_q + 2'd1;
        end else if (cnt_q == CntLast) begin
          state_d = (state_q == StShow) ? StHide : StShow;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: begin
        state_d  = StIdle;
        cnt_d    = '0;
        cursor_d = 2'd0;
      end
    endcase
  end

  // Outputs are derived from the next state so they change on the same edge.
  always_comb begin
    editing_d  = (state_d != StIdle);
    blink_ph_d = (state_d != StHide);
    digit_on_d = '1;
    for (int unsigned c = 0; c < NUM_FIELDS; c++) begin
      if (editing_d && (cursor_d == 2'(c))) begin
        digit_on_d[2*c +: 2] = {2{blink_ph_d}};
      end
    end
  end

  // FSM state, phase counter and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= StIdle;
      cnt_q      <= '0;
      cursor_q   <= 2'd0;
      editing_q  <= 1'b0;
      blink_ph_q <= 1'b1;
      digit_on_q <= '1;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      cursor_q   <= cursor_d;
      editing_q  <= editing_d;
      blink_ph_q <= blink_ph_d;
      digit_on_q <= digit_on_d;
    end
  end

  assign editing  = editing_q;
  assign cursor   = cursor_q;
  assign blink_ph = blink_ph_q;
  assign digit_on = digit_on_q;

endmodule
